reg_dump_unit: RTL and testbench
================================

REG_DUMP_UNIT -- requirements
Module: reg_dump_unit

Interface
REQ-001 SHALL provide parameter FIRST_REG, default 1, as the first register index dumped (0..7).
REQ-002 SHALL provide parameter LAST_REG, default 6, as the last register index dumped (FIRST_REG..7).
REQ-003 SHALL provide port clk  input  1  clock; all state updates on the rising edge.
REQ-004 SHALL provide port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL provide port start  input  1  request to begin a dump, sampled in IDLE only.
REQ-006 SHALL provide port rf_addr  output  3  register-file read address, driving the register file's combinational read port.
REQ-007 SHALL provide port rf_data  input  32  combinational read data for rf_addr.
REQ-008 SHALL provide port out_data  output  32  streamed word.
REQ-009 SHALL provide port out_index  output  3  register index of out_data.
REQ-010 SHALL provide port out_valid  output  1  out_data, out_index and out_last are valid.
REQ-011 SHALL provide port out_ready  input  1  consumer accepts the word.
REQ-012 SHALL provide port out_last  output  1  final word of the dump.
REQ-013 SHALL provide port busy  output  1  high in every state except IDLE.
REQ-014 SHALL provide port done  output  1  one-cycle pulse when the dump completes.

Function
REQ-015 SHALL implement states IDLE, LOAD, SEND, DONE (plus CSUM when checksum is enabled, see REQ-029).
REQ-016 IDLE: start=1 at an edge SHALL set idx=FIRST_REG and go to LOAD; start=0 SHALL stay in IDLE.
REQ-017 rf_addr SHALL equal idx in all states; rf_addr is 0 in IDLE.
REQ-018 LOAD: at the next edge SHALL capture rf_data into out_data, capture idx into out_index, set out_valid=1, and go to SEND.
REQ-019 Latency: start sampled at edge N SHALL give out_valid=1 after edge N+1.
REQ-020 SEND with out_ready=0: out_valid, out_data, out_index and out_last SHALL hold stable.
REQ-021 SEND with out_valid&out_ready at an edge:
  - if idx<LAST_REG, SHALL clear out_valid, increment idx and go to LOAD (one-cycle bubble per word);
  - if idx==LAST_REG, SHALL go to DONE, or to CSUM when checksum is enabled.
REQ-022 out_last SHALL be 1 only on the final word of the dump.
REQ-023 DONE: SHALL assert done for exactly one cycle, clear out_valid and return to IDLE at the next edge.
REQ-024 start while busy=1 SHALL be ignored, with no queuing.
REQ-025 FIRST_REG==LAST_REG SHALL yield exactly one word, with out_last=1.
REQ-026 idx SHALL never wrap past 7; LAST_REG=7 SHALL terminate without incrementing idx to 0.

Reset
REQ-027 rst=1 SHALL force, asynchronously and at any state including mid-dump:
  - state=IDLE, idx=0;
  - out_valid=0, out_last=0, done=0, busy=0;
  - out_data=0, out_index=0, checksum=0.
REQ-028 After reset deassertion, no word SHALL be emitted until a new start.

Configuration
REQ-029 With macro REG_DUMP_CHECKSUM_EN defined:
  - SHALL keep a 32-bit running XOR of every accepted register word, cleared on start;
  - after the LAST_REG word is accepted, SHALL emit one extra word in state CSUM: out_data=XOR, out_index=0, out_last=1;
  - on acceptance of that word, SHALL go to DONE;
  - out_last SHALL be 0 on all register words.
REQ-030 Without REG_DUMP_CHECKSUM_EN: no CSUM state and no checksum register; out_last=1 on the LAST_REG word.

Verification
REQ-031 Reset mid-operation: assert rst during SEND of r3 -> out_valid=0 and busy=0 immediately; no further words.
REQ-032 Default parameters, out_ready=1, r1..r6=0x11,0x22,0x33,0x44,0x55,0x66 -> six words in order, out_index 1..6, out_last only on 0x66 (macro off), done pulses once.
REQ-033 Backpressure: hold out_ready=0 for 5 cycles on r2=0xDEADBEEF -> out_data and out_index stay stable for all 5 cycles; word accepted on first out_ready=1.
REQ-034 Start issued at the 2nd word -> ignored; exactly 6 words and one done.
REQ-035 Macro on, r1..r6=1,2,4,8,16,32 -> 7th word 0x0000003F, out_index 0, out_last=1.
REQ-036 FIRST_REG=LAST_REG=7, r7=0xA5A5A5A5 -> single word with out_last=1 (macro off), idx ends at 7, done pulses.

Source files
------------

// File: rtl/reg_dump_unit.sv
// Streams register-file entries FIRST_REG..LAST_REG over a valid/ready port.
// Optional trailing XOR checksum word when REG_DUMP_CHECKSUM_EN is defined.
module reg_dump_unit #(
  parameter int unsigned FIRST_REG = 1,
  parameter int unsigned LAST_REG  = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [2:0]  rf_addr,
  input  logic [31:0] rf_data,
  output logic [31:0] out_data,
  output logic [2:0]  out_index,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        busy,
  output logic        done
);

  localparam int unsigned IDX_W  = 3;
  localparam int unsigned DATA_W = 32;
  localparam logic [IDX_W-1:0] FIRST_IDX = IDX_W'(FIRST_REG);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(LAST_REG);

`ifdef REG_DUMP_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, LOAD, SEND, DONE, CSUM} state_e;
  localparam logic REG_LAST_FLAG = 1'b0;
`else
  typedef enum logic [1:0] {IDLE, LOAD, SEND, DONE} state_e;
  localparam logic REG_LAST_FLAG = 1'b1;
`endif

  state_e state_q, state_d;

  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [IDX_W-1:0]  out_index_q, out_index_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
`ifdef REG_DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q, csum_d;
`endif

  logic accept;
  assign accept = out_valid_q & out_ready;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = LOAD;
      LOAD: state_d = SEND;
      SEND: begin
        if (accept) begin
          if (idx_q < LAST_IDX) state_d = LOAD;
`ifdef REG_DUMP_CHECKSUM_EN
          else                  state_d = CSUM;
`else
          else                  state_d = DONE;
`endif
        end
      end
`ifdef REG_DUMP_CHECKSUM_EN
      CSUM: if (accept) state_d = DONE;
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    idx_d       = idx_q;
    out_data_d  = out_data_q;
    out_index_d = out_index_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
`ifdef REG_DUMP_CHECKSUM_EN
    csum_d      = csum_q;
`endif
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == DONE);
    case (state_q)
      IDLE: begin
        if (start) begin
          idx_d = FIRST_IDX;
`ifdef REG_DUMP_CHECKSUM_EN
          csum_d = '0;
`endif
        end
      end
      LOAD: begin
        out_data_d  = rf_data;
        out_index_d = idx_q;
        out_valid_d = 1'b1;
        out_last_d  = REG_LAST_FLAG & (idx_q == LAST_IDX);
      end
      SEND: begin
        if (accept) begin
`ifdef REG_DUMP_CHECKSUM_EN
          csum_d = csum_q ^ out_data_q;
`endif
          if (idx_q < LAST_IDX) begin
            idx_d       = idx_q + IDX_W'(1);
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
          end else begin
`ifdef REG_DUMP_CHECKSUM_EN
            // Present the checksum including the word just accepted
            out_data_d  = csum_q ^ out_data_q;
            out_index_d = '0;
            out_last_d  = 1'b1;
            out_valid_d = 1'b1;
`else
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
`endif
          end
        end
      end
`ifdef REG_DUMP_CHECKSUM_EN
      CSUM: begin
        if (accept) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
        end
      end
`endif
      DONE: begin
        idx_d       = '0;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q       <= '0;
      out_data_q  <= '0;
      out_index_q <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      idx_q       <= idx_d;
      out_data_q  <= out_data_d;
      out_index_q <= out_index_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef REG_DUMP_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  assign rf_addr   = idx_q;
  assign out_data  = out_data_q;
  assign out_index = out_index_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_reg_dump_unit.sv
// Self-checking bench for reg_dump_unit: default instance plus a FIRST_REG=LAST_REG=7 instance.
module tb_reg_dump_unit;

  typedef struct packed {
    logic [31:0] data;
    logic [2:0]  index;
    logic        last;
  } word_t;

`ifdef REG_DUMP_CHECKSUM_EN
  localparam logic EXP_REG_LAST = 1'b0;
  localparam int   N_WORDS      = 7;
`else
  localparam logic EXP_REG_LAST = 1'b1;
  localparam int   N_WORDS      = 6;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start, start7;
  logic [2:0]  rf_addr, rf_addr7;
  logic [31:0] rf_data, rf_data7;
  logic [31:0] out_data, out_data7;
  logic [2:0]  out_index, out_index7;
  logic        out_valid, out_valid7;
  logic        out_ready, out_ready7;
  logic        out_last, out_last7;
  logic        busy, busy7;
  logic        done, done7;

  logic [31:0] rf [8];
  word_t       exp_q [$];
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  assign rf_data  = rf[rf_addr];
  assign rf_data7 = rf[rf_addr7];

  reg_dump_unit dut (
    .clk(clk), .rst(rst), .start(start),
    .rf_addr(rf_addr), .rf_data(rf_data),
    .out_data(out_data), .out_index(out_index), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .busy(busy), .done(done)
  );

  reg_dump_unit #(.FIRST_REG(7), .LAST_REG(7)) dut7 (
    .clk(clk), .rst(rst), .start(start7),
    .rf_addr(rf_addr7), .rf_data(rf_data7),
    .out_data(out_data7), .out_index(out_index7), .out_valid(out_valid7),
    .out_ready(out_ready7), .out_last(out_last7), .busy(busy7), .done(done7)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Expected stream for a dump of rf[first..last], including the checksum word when enabled
  task automatic push_dump(input int first, input int last);
    logic [31:0] x;
    word_t       w;
    x = '0;
    for (int i = first; i <= last; i++) begin
      w.data  = rf[i];
      w.index = 3'(i);
      w.last  = EXP_REG_LAST & (i == last);
      x       = x ^ rf[i];
      exp_q.push_back(w);
    end
`ifdef REG_DUMP_CHECKSUM_EN
    w.data  = x;
    w.index = 3'd0;
    w.last  = 1'b1;
    exp_q.push_back(w);
`endif
  endtask

  // Start pulse, then check the LOAD cycle
  task automatic kick();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("load_busy", 32'(busy), 32'd1);
    check("load_valid", 32'(out_valid), 32'd0);
    check("load_rf_addr", 32'(rf_addr), 32'd1);
  endtask

  // Consume words, comparing each accepted one against the scoreboard
  task automatic drain(input int n_words, input int stall_word, input int stall_len,
                       input int start_word);
    int          seen, dones, stalls, cyc, first_cyc;
    bit          injected, finished;
    logic [31:0] held_data;
    logic [2:0]  held_idx;
    word_t       w;
    seen = 0; dones = 0; stalls = 0; cyc = 0; first_cyc = -1;
    injected = 1'b0; finished = 1'b0;
    held_data = '0; held_idx = '0;
    while (!finished && cyc < 200) begin
      @(negedge clk);
      cyc++;
      start     = 1'b0;
      out_ready = 1'b1;
      if (done) dones++;
      if (out_valid && first_cyc < 0) first_cyc = cyc;
      if (out_valid && seen == start_word && !injected) begin
        start    = 1'b1;
        injected = 1'b1;
      end
      if (out_valid && seen == stall_word) begin
        if (stalls == 0) begin
          held_data = out_data;
          held_idx  = out_index;
        end else begin
          check("stall_data", out_data, held_data);
          check("stall_index", 32'(out_index), 32'(held_idx));
        end
        if (stalls < stall_len) begin
          out_ready = 1'b0;
          stalls++;
        end
      end
      if (out_valid && out_ready) begin
        check("word_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          w = exp_q.pop_front();
          check("word_data", out_data, w.data);
          check("word_index", 32'(out_index), 32'(w.index));
          check("word_last", 32'(out_last), 32'(w.last));
        end
        seen++;
      end
      if (dones > 0 && !busy && !out_valid) finished = 1'b1;
    end
    check("drain_finished", 32'(finished), 32'd1);
    check("first_word_latency", 32'(first_cyc), 32'd1);
    check("word_count", 32'(seen), 32'(n_words));
    check("done_count", 32'(dones), 32'd1);
    check("idle_rf_addr", 32'(rf_addr), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  vcount;
    bit  found;
    rst = 1'b1; start = 1'b0; start7 = 1'b0;
    out_ready = 1'b1; out_ready7 = 1'b1;
    for (int i = 0; i < 8; i++) rf[i] = 32'h1000_0000 + 32'(i);

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_last", 32'(out_last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_data", out_data, 32'd0);
    check("rst_index", 32'(out_index), 32'd0);
    check("rst_rf_addr", 32'(rf_addr), 32'd0);
    rst = 1'b0;

    // No output without start
    vcount = 0;
    repeat (4) begin
      @(negedge clk);
      if (out_valid || busy || done) vcount++;
    end
    check("idle_quiet", 32'(vcount), 32'd0);

    // Basic dump of 0x11..0x66
    for (int i = 1; i <= 6; i++) rf[i] = 32'h11 * 32'(i);
    push_dump(1, 6);
    kick();
    drain(N_WORDS, -1, 0, -1);

    // Backpressure on r2
    rf[2] = 32'hDEAD_BEEF;
    push_dump(1, 6);
    kick();
    drain(N_WORDS, 1, 5, -1);

    // Start during the 2nd word is ignored
    for (int i = 1; i <= 6; i++) rf[i] = 32'hA000_0000 | 32'(i * 3);
    push_dump(1, 6);
    kick();
    drain(N_WORDS, -1, 0, 1);
    vcount = 0;
    repeat (4) begin
      @(negedge clk);
      if (out_valid || busy) vcount++;
    end
    check("no_queued_start", 32'(vcount), 32'd0);

    // Power-of-two pattern (checksum 0x3F when enabled)
    for (int i = 1; i <= 6; i++) rf[i] = 32'd1 << (i - 1);
    push_dump(1, 6);
    kick();
    drain(N_WORDS, -1, 0, -1);

    // Single-word dump of r7
    rf[7] = 32'hA5A5_A5A5;
    @(negedge clk);
    start7 = 1'b1;
    @(negedge clk);
    start7 = 1'b0;
    check("r7_load_busy", 32'(busy7), 32'd1);
    check("r7_load_addr", 32'(rf_addr7), 32'd7);
    check("r7_load_valid", 32'(out_valid7), 32'd0);
    @(negedge clk);
    check("r7_valid", 32'(out_valid7), 32'd1);
    check("r7_data", out_data7, 32'hA5A5_A5A5);
    check("r7_index", 32'(out_index7), 32'd7);
    check("r7_last", 32'(out_last7), 32'(EXP_REG_LAST));
`ifdef REG_DUMP_CHECKSUM_EN
    @(negedge clk);
    check("r7_csum_valid", 32'(out_valid7), 32'd1);
    check("r7_csum_data", out_data7, 32'hA5A5_A5A5);
    check("r7_csum_index", 32'(out_index7), 32'd0);
    check("r7_csum_last", 32'(out_last7), 32'd1);
`endif
    @(negedge clk);
    check("r7_done", 32'(done7), 32'd1);
    check("r7_done_valid", 32'(out_valid7), 32'd0);
    check("r7_idx_end", 32'(rf_addr7), 32'd7);
    @(negedge clk);
    check("r7_done_pulse", 32'(done7), 32'd0);
    check("r7_idle_busy", 32'(busy7), 32'd0);

    // Reset in the middle of a dump, while r3 is held
    for (int i = 1; i <= 6; i++) rf[i] = 32'h11 * 32'(i);
    kick();
    found = 1'b0;
    for (int c = 0; c < 30 && !found; c++) begin
      @(negedge clk);
      if (out_valid && out_index == 3'd3) begin
        found     = 1'b1;
        out_ready = 1'b0;
      end else begin
        out_ready = 1'b1;
      end
    end
    check("r3_reached", 32'(found), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_data", out_data, 32'd0);
    check("midrst_index", 32'(out_index), 32'd0);
    check("midrst_rf_addr", 32'(rf_addr), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    vcount = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid || busy || done) vcount++;
    end
    check("midrst_no_words", 32'(vcount), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
